// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port single-memory arbiter for a CHIP-8 style system.
// p0 = CPU, p1 = display/sprite engine. One access issues per cycle, with
// mem_* driven combinationally from the winner; ack and read data come back
// one cycle later.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on a tie;
// without it p0 always wins a tie (fixed priority).
module mem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic              last_grant;
   logic              p0_ack_q, p1_ack_q;
   logic              p0_rd_q, p1_rd_q;
   logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
   logic              elig0, elig1, tie_pick1, gnt0, gnt1;

   // A reset arriving in the ack cycle kills the ack and any read data.
   assign p0_ack = p0_ack_q & ~reset;
   assign p1_ack = p1_ack_q & ~reset;

   // A port in its ack cycle sits out, so a held req cannot double-issue.
   assign elig0 = p0_req & ~p0_ack & ~reset;
   assign elig1 = p1_req & ~p1_ack & ~reset;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Tie goes to whichever port did not win last time.
   assign tie_pick1 = ~last_grant;
`else
   // Fixed priority: p0 wins every tie; last_grant is tracked but has no say.
   assign tie_pick1 = 1'b0 & ~last_grant;
`endif

   assign gnt1 = elig1 & (~elig0 | tie_pick1);
   assign gnt0 = elig0 & ~gnt1;

   // Route the winning port to the memory; all zero when idle.
   always_comb begin
      mem_en    = gnt0 | gnt1;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt1) begin
         mem_we    = p1_we;
         mem_addr  = p1_addr;
         mem_wdata = p1_wdata;
      end else if (gnt0) begin
         mem_we    = p0_we;
         mem_addr  = p0_addr;
         mem_wdata = p0_wdata;
      end
   end

   // Read data is passed through live in the ack cycle, then held.
   always_comb begin
      p0_rdata = p0_rdata_q;
      p1_rdata = p1_rdata_q;
      if (reset) begin
         p0_rdata = '0;
         p1_rdata = '0;
      end else begin
         if (p0_ack_q && p0_rd_q) p0_rdata = mem_rdata;
         if (p1_ack_q && p1_rd_q) p1_rdata = mem_rdata;
      end
   end

   // Ack/read tracking, read capture and last-grant bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         p0_ack_q   <= 1'b0;
         p1_ack_q   <= 1'b0;
         p0_rd_q    <= 1'b0;
         p1_rd_q    <= 1'b0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
         last_grant <= 1'b1;
      end else begin
         p0_ack_q <= gnt0;
         p1_ack_q <= gnt1;
         p0_rd_q  <= gnt0 & ~p0_we;
         p1_rd_q  <= gnt1 & ~p1_we;
         if (p0_ack_q && p0_rd_q) p0_rdata_q <= mem_rdata;
         if (p1_ack_q && p1_rd_q) p1_rdata_q <= mem_rdata;
         if (gnt0 || gnt1) last_grant <= gnt1;
      end
   end

endmodule
